ann_layer_mac_scheduler: RTL

// - Time-multiplexes one shared signed 19x24->40 combinational multiplier across a

---
 rtl/ann_pkg.sv | 22 ++
 rtl/ann_layer_mac_scheduler_if.sv | 13 +
 rtl/ann_mac_acc.sv | 50 +++++
 rtl/ann_layer_mac_scheduler.sv | 139 +++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared types and widths for the ANN layer MAC scheduler.
package ann_pkg;

   localparam int A_W   = 19;
   localparam int B_W   = 24;
   localparam int P_W   = 40;
   localparam int ACC_W = 46;
   localparam int IDX_W = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_OUT
   } state_t;

   // Sign-extend a multiplier product to accumulator width.
   function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [P_W-1:0] p);
      return {{(ACC_W-P_W){p[P_W-1]}}, p};
   endfunction

endpackage

// File: rtl/ann_layer_mac_scheduler_if.sv
// Result stream from the scheduler to the next-layer activation stage.
interface ann_layer_mac_scheduler_if;
   import ann_pkg::*;

   logic [ACC_W-1:0] y_data;
   logic [IDX_W-1:0] y_idx;
   logic             y_valid;
   logic             y_ready;

   modport master (output y_data, output y_idx, output y_valid, input y_ready);
   modport slave  (input y_data, input y_idx, input y_valid, output y_ready);

endinterface

// File: rtl/ann_mac_acc.sv
// Accumulator behind the shared multiplier. Read-valid is the RAM enable
// delayed one cycle; the first product of a neuron loads the register
// instead of adding, so no clear is needed between neurons.
module ann_mac_acc
   import ann_pkg::*;
(
   input  logic                    ap_clk,
   input  logic                    ap_rst,
   input  logic                    rd_i,
   input  logic                    first_i,
   input  logic                    clr_i,
   input  logic signed [P_W-1:0]   mul_p_i,
   output logic signed [ACC_W-1:0] acc_o
);

   logic                    rd_vld_q;
   logic                    first_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;

   // Next accumulator value: clear on pass start, load or add when data is valid.
   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (rd_vld_q) begin
         if (first_q) begin
            acc_d = sext_prod(mul_p_i);
         end else begin
            acc_d = acc_q + sext_prod(mul_p_i);
         end
      end
   end

   // Read-valid pipeline and accumulator register.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         rd_vld_q <= 1'b0;
         first_q  <= 1'b0;
         acc_q    <= '0;
      end else begin
         rd_vld_q <= rd_i;
         first_q  <= rd_i & first_i;
         acc_q    <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/ann_layer_mac_scheduler.sv
// Fully-connected layer scheduler: walks inputs x neurons through one
// external multiplier and streams one accumulated sum per neuron.
//
// state   | meaning
// S_IDLE  | waiting for ap_start
// S_FETCH | issuing x/w RAM reads for input i of neuron o
// S_DRAIN | last product of the neuron lands in the accumulator
// S_OUT   | presenting y_data/y_idx until downstream accepts
module ann_layer_mac_scheduler
   import ann_pkg::*;
#(
   parameter int N_IN  = 50,
   parameter int N_OUT = 50,
   parameter int XA_W  = (N_IN > 1) ? $clog2(N_IN) : 1,
   parameter int WA_W  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  ap_start,
   output logic                  ap_idle,
   output logic                  ap_ready,
   output logic                  ap_done,
   output logic [XA_W-1:0]       x_addr,
   output logic                  x_ce,
   input  logic signed [A_W-1:0] x_q,
   output logic [WA_W-1:0]       w_addr,
   output logic                  w_ce,
   input  logic signed [B_W-1:0] w_q,
   output logic signed [A_W-1:0] mul_a,
   output logic signed [B_W-1:0] mul_b,
   input  logic signed [P_W-1:0] mul_p,
   ann_layer_mac_scheduler_if.master y_if
);

   localparam logic [XA_W-1:0]  I_LAST = XA_W'(N_IN - 1);
   localparam logic [IDX_W-1:0] O_LAST = IDX_W'(N_OUT - 1);

   state_t                  state_q, state_d;
   logic [XA_W-1:0]         i_q, i_d;
   logic [IDX_W-1:0]        o_q, o_d;
   logic [WA_W-1:0]         w_addr_q, w_addr_d;
   logic                    fetch;
   logic                    clr_acc;
   logic                    done;
   logic signed [ACC_W-1:0] acc;

   // State and counter registers.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q  <= S_IDLE;
         i_q      <= '0;
         o_q      <= '0;
         w_addr_q <= '0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         o_q      <= o_d;
         w_addr_q <= w_addr_d;
      end
   end

   // Next-state and control decode; w_addr is a running count, not o*N_IN+i.
   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      o_d      = o_q;
      w_addr_d = w_addr_q;
      fetch    = 1'b0;
      clr_acc  = 1'b0;
      done     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ap_start) begin
               state_d  = S_FETCH;
               i_d      = '0;
               o_d      = '0;
               w_addr_d = '0;
               clr_acc  = 1'b1;
            end
         end
         S_FETCH: begin
            fetch    = 1'b1;
            w_addr_d = w_addr_q + WA_W'(1);
            if (i_q == I_LAST) begin
               i_d     = '0;
               state_d = S_DRAIN;
            end else begin
               i_d = i_q + XA_W'(1);
            end
         end
         S_DRAIN: begin
            state_d = S_OUT;
         end
         S_OUT: begin
            if (y_if.y_ready) begin
               if (o_q == O_LAST) begin
                  done    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  o_d     = o_q + IDX_W'(1);
                  i_d     = '0;
                  state_d = S_FETCH;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   ann_mac_acc u_mac_acc (
      .ap_clk  (ap_clk),
      .ap_rst  (ap_rst),
      .rd_i    (fetch),
      .first_i (i_q == '0),
      .clr_i   (clr_acc),
      .mul_p_i (mul_p),
      .acc_o   (acc)
   );

   assign ap_idle  = (state_q == S_IDLE);
   assign ap_done  = done;
   assign ap_ready = done;

   assign x_ce   = fetch;
   assign w_ce   = fetch;
   assign x_addr = i_q;
   assign w_addr = w_addr_q;

   // RAM outputs feed the multiplier directly; product lands in acc the same cycle.
   assign mul_a = x_q;
   assign mul_b = w_q;

   assign y_if.y_valid = (state_q == S_OUT);
   assign y_if.y_data  = acc;
   assign y_if.y_idx   = o_q;

endmodule
